// File: rtl/ex_div.sv
// rtl/ex_div.sv - multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage
module ex_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             stall_req,
  output logic             div_done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_busy
);

  typedef enum logic [1:0] {IDLE, DIVZERO, CALC, DONE} state_e;

  state_e           state_q;
  logic [5:0]       cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dsr_q;
  logic             q_neg_q, r_neg_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;

  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] rem_d, quo_d;

  // One restoring step: shift in the next dividend bit and subtract if it fits.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dsr_q};
    if (!trial[WIDTH]) begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = rem_sh[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (div_start) begin
            cnt_q <= '0;
            if (divisor == '0) begin
              quo_q   <= dividend;
              state_q <= DIVZERO;
            end else begin
              // Magnitudes only for DIV; 0x80000000 wraps to itself, which yields the overflow result.
              rem_q   <= '0;
              quo_q   <= (div_signed && dividend[WIDTH-1]) ? -dividend : dividend;
              dsr_q   <= (div_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
              q_neg_q <= div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              r_neg_q <= div_signed & dividend[WIDTH-1];
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'(WIDTH - 1)) begin
            quotient_q  <= q_neg_q ? -quo_d : quo_d;
            remainder_q <= r_neg_q ? -rem_d : rem_d;
            state_q     <= DONE;
          end
        end
        DIVZERO: begin
          quotient_q  <= '1;
          remainder_q <= quo_q;
          state_q     <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_req = (state_q == IDLE && div_start && !flush) ||
                     state_q == CALC || state_q == DIVZERO;
  assign div_done  = (state_q == DONE);
  assign div_busy  = (state_q != IDLE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - randomized self-checking bench for ex_div against an arithmetic reference
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst, flush, div_start, div_signed;
  logic [31:0] dividend, divisor;
  logic        stall_req, div_done, div_busy;
  logic [31:0] quotient, remainder;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_div #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .div_start(div_start),
    .div_signed(div_signed), .dividend(dividend), .divisor(divisor),
    .stall_req(stall_req), .div_done(div_done), .quotient(quotient),
    .remainder(remainder), .div_busy(div_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division at 64 bits so the signed overflow case cannot trap.
  task automatic model(input logic sg, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFFFFFF;
      r = a;
    end else if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input bit poke);
    int cyc;
    bit stall_ok;
    div_signed = sg; dividend = a; divisor = b; div_start = 1'b1;
    #1;
    chk("stall_at_start", stall_req, 1);
    tick();
    div_start = 1'b0;
    cyc = 1;
    stall_ok = 1'b1;
    while (!div_done && cyc < 40) begin
      if (!stall_req) stall_ok = 1'b0;
      if (poke && (cyc == 5 || cyc == 17)) begin
        div_start = 1'b1; div_signed = $urandom_range(0, 1);
        dividend = $urandom; divisor = $urandom;
      end else begin
        div_start = 1'b0;
      end
      tick();
      cyc++;
    end
    div_start = 1'b0;
    chk("latency", cyc, (b == 32'd0) ? 2 : 33);
    chk("stall_busy", stall_ok, 1);
    chk("stall_in_done", stall_req, 0);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    tick();
    chk("done_one_cycle", div_done, 0);
  endtask

  initial begin
    logic [31:0] eq, er, pq, pr, a, b;
    logic sg;
    int dones;

    rst = 1'b1; flush = 1'b0; div_start = 1'b0; div_signed = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) tick();
    chk("rst_done", div_done, 0);
    chk("rst_busy", div_busy, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_quo", quotient, 0);
    chk("rst_rem", remainder, 0);
    rst = 1'b0;
    tick();

    run_div(0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
    run_div(1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0);
    run_div(1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 0);
    run_div(0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 0);
    run_div(1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0);
    run_div(0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 0);
    run_div(0, 32'd5, 32'd9, 32'd0, 32'd5, 1);

    for (int i = 0; i < 30; i++) begin
      sg = $urandom_range(0, 1);
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 300);
        3:       b = 32'hFFFFFFFF - $urandom_range(0, 300);
        default: b = $urandom;
      endcase
      model(sg, a, b, eq, er);
      run_div(sg, a, b, eq, er, (i % 4) == 0);
    end

    // Flush mid-CALC with a coincident start: abort, keep old results.
    pq = quotient; pr = remainder;
    div_signed = 1'b0; dividend = $urandom; divisor = 32'd3; div_start = 1'b1;
    tick();
    div_start = 1'b0;
    repeat (9) tick();
    flush = 1'b1; div_start = 1'b1;
    tick();
    flush = 1'b0; div_start = 1'b0;
    chk("flush_busy", div_busy, 0);
    chk("flush_done", div_done, 0);
    chk("flush_quo_hold", quotient, pq);
    chk("flush_rem_hold", remainder, pr);
    dones = 0;
    for (int c = 0; c < 36; c++) begin
      if (div_done) dones++;
      tick();
    end
    chk("flush_no_done", dones, 0);

    flush = 1'b1; div_start = 1'b1;
    #1;
    chk("flush_idle_stall", stall_req, 0);
    tick();
    flush = 1'b0; div_start = 1'b0;
    chk("flush_start_dropped", div_busy, 0);
    model(1, 32'hFFFF0000, 32'd77, eq, er);
    run_div(1, 32'hFFFF0000, 32'd77, eq, er, 0);

    // Reset mid-CALC: everything clears and no done pulse follows.
    div_signed = 1'b1; dividend = $urandom; divisor = 32'd11; div_start = 1'b1;
    tick();
    div_start = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", div_busy, 0);
    chk("midrst_done", div_done, 0);
    chk("midrst_stall", stall_req, 0);
    chk("midrst_quo", quotient, 0);
    chk("midrst_rem", remainder, 0);
    dones = 0;
    for (int c = 0; c < 36; c++) begin
      if (div_done) dones++;
      tick();
    end
    chk("midrst_no_done", dones, 0);
    model(0, 32'd1000, 32'd33, eq, er);
    run_div(0, 32'd1000, 32'd33, eq, er, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
